// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: states, opcodes, functs,
// ALU codes and datapath select codes.
package mcpu_pkg;

    typedef enum logic [4:0] {
        StIf  = 5'd0,
        StId  = 5'd1,
        StMa  = 5'd2,
        StMrd = 5'd3,
        StWbl = 5'd4,
        StMwr = 5'd5,
        StExr = 5'd6,
        StWbr = 5'd7,
        StBr  = 5'd8,
        StJmp = 5'd9,
        StExi = 5'd10,
        StWbi = 5'd11,
        StJal = 5'd12
    } state_e;

    // How the ALU decoder picks its operation in the current microstep.
    typedef enum logic [1:0] {
        AluOpAdd,
        AluOpSub,
        AluOpFunct,
        AluOpImm
    } alu_op_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSrl = 6'h02;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnXor = 6'h26;
    localparam logic [5:0] FnNor = 6'h27;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluXor = 3'b011;
    localparam logic [2:0] AluNor = 3'b100;
    localparam logic [2:0] AluSrl = 3'b101;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [1:0] RegDstRt = 2'b00;
    localparam logic [1:0] RegDstRd = 2'b01;
    localparam logic [1:0] RegDstRa = 2'b10;

    localparam logic [1:0] MemtoRegAlu = 2'b00;
    localparam logic [1:0] MemtoRegMdr = 2'b01;
    localparam logic [1:0] MemtoRegPc  = 2'b10;

    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    function automatic logic funct_known(logic [5:0] fn);
        case (fn)
            FnSrl, FnAdd, FnSub, FnAnd, FnOr, FnXor, FnNor, FnSlt: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mcpu_ctrl_fsm_if.sv
// Control bundle between the multi-cycle control FSM (master) and the shared datapath (slave).
interface mcpu_ctrl_fsm_if;
    logic [31:0] Inst_in;
    logic        zero;
    logic        MIO_ready;
    logic        MemRead;
    logic        MemWrite;
    logic        CPU_MIO;
    logic        IorD;
    logic        IRWrite;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        RegWrite;
    logic        Branch;
    logic [1:0]  RegDst;
    logic [1:0]  MemtoReg;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSource;
    logic [2:0]  ALU_Control;
    logic [4:0]  state_out;

    modport master (
        input  Inst_in, zero, MIO_ready,
        output MemRead, MemWrite, CPU_MIO, IorD, IRWrite, PCWrite, PCWriteCond, RegWrite,
               Branch, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALU_Control, state_out
    );

    modport slave (
        output Inst_in, zero, MIO_ready,
        input  MemRead, MemWrite, CPU_MIO, IorD, IRWrite, PCWrite, PCWriteCond, RegWrite,
               Branch, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALU_Control, state_out
    );
endinterface

// File: rtl/mcpu_alu_dec.sv
// Combinational ALU operation decoder: fixed add/sub, R-type funct, or I-type opcode mapping.
module mcpu_alu_dec
    import mcpu_pkg::*;
(
    input  alu_op_e    alu_op_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       funct_known_o
);

    assign funct_known_o = funct_known(funct_i);

    always_comb begin
        alu_ctrl_o = AluAdd;
        unique case (alu_op_i)
            AluOpAdd: alu_ctrl_o = AluAdd;
            AluOpSub: alu_ctrl_o = AluSub;
            AluOpFunct: begin
                case (funct_i)
                    FnAdd:   alu_ctrl_o = AluAdd;
                    FnSub:   alu_ctrl_o = AluSub;
                    FnAnd:   alu_ctrl_o = AluAnd;
                    FnOr:    alu_ctrl_o = AluOr;
                    FnSlt:   alu_ctrl_o = AluSlt;
                    FnNor:   alu_ctrl_o = AluNor;
                    FnSrl:   alu_ctrl_o = AluSrl;
                    FnXor:   alu_ctrl_o = AluXor;
                    default: alu_ctrl_o = AluAdd;
                endcase
            end
            AluOpImm: begin
                case (opcode_i)
                    OpSlti:  alu_ctrl_o = AluSlt;
                    OpAndi:  alu_ctrl_o = AluAnd;
                    OpOri:   alu_ctrl_o = AluOr;
                    default: alu_ctrl_o = AluAdd;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS-subset control FSM: Moore machine sequencing the shared datapath.
// Optional jal support is enabled by defining MCPU_JAL_EN.
module mcpu_ctrl_fsm
    import mcpu_pkg::*;
#(
    parameter logic [4:0] INIT_STATE = 5'd0
) (
    input  logic              clk,
    input  logic              reset,
    mcpu_ctrl_fsm_if.master   bus
);

    state_e     state_q, state_d;
    alu_op_e    alu_op;
    logic [2:0] alu_ctrl;
    logic       fn_known;
    logic [5:0] opcode, funct;

    assign opcode = bus.Inst_in[31:26];
    assign funct  = bus.Inst_in[5:0];

    // zero is consumed by the datapath's branch logic, not by sequencing.
    logic unused_in;
    assign unused_in = ^{bus.zero, bus.Inst_in[25:6]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= state_e'(INIT_STATE);
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIf: if (bus.MIO_ready) state_d = StId;
            StId: begin
                case (opcode)
                    OpRtype:                        state_d = StExr;
                    OpLw, OpSw:                     state_d = StMa;
                    OpBeq, OpBne:                   state_d = StBr;
                    OpJ:                            state_d = StJmp;
`ifdef MCPU_JAL_EN
                    OpJal:                          state_d = StJal;
`else
                    OpJal:                          state_d = StIf;
`endif
                    OpAddi, OpSlti, OpAndi, OpOri:  state_d = StExi;
                    default:                        state_d = StIf;
                endcase
            end
            StMa:    state_d = (opcode == OpLw) ? StMrd : StMwr;
            StMrd:   if (bus.MIO_ready) state_d = StWbl;
            StMwr:   if (bus.MIO_ready) state_d = StIf;
            StExr:   state_d = StWbr;
            StExi:   state_d = StWbi;
            default: state_d = StIf;
        endcase
    end

    // Reset forces every control to its idle value, independent of the latched state.
    always_comb begin
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IorD        = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.Branch      = 1'b0;
        bus.RegDst      = RegDstRt;
        bus.MemtoReg    = MemtoRegAlu;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = SrcBReg;
        bus.PCSource    = PcSrcAlu;
        alu_op          = AluOpAdd;
        if (!reset) begin
            case (state_q)
                StIf: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = SrcBFour;
                    bus.IRWrite = bus.MIO_ready;
                    bus.PCWrite = bus.MIO_ready;
                end
                StId: bus.ALUSrcB = SrcBImmSh2;
                StMa: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = SrcBImm;
                end
                StMrd: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                StWbl: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = MemtoRegMdr;
                end
                StMwr: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                StExr: begin
                    bus.ALUSrcA = 1'b1;
                    alu_op      = AluOpFunct;
                end
                StWbr: begin
                    bus.RegWrite = fn_known;
                    bus.RegDst   = RegDstRd;
                end
                StBr: begin
                    bus.ALUSrcA     = 1'b1;
                    alu_op          = AluOpSub;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = PcSrcAluOut;
                    bus.Branch      = (opcode == OpBeq);
                end
                StJmp: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = PcSrcJump;
                end
                StExi: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = SrcBImm;
                    alu_op      = AluOpImm;
                end
                StWbi: bus.RegWrite = 1'b1;
`ifdef MCPU_JAL_EN
                StJal: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = RegDstRa;
                    bus.MemtoReg = MemtoRegPc;
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = PcSrcJump;
                end
`endif
                default: ;
            endcase
        end
    end

    mcpu_alu_dec u_alu_dec (
        .alu_op_i      (alu_op),
        .opcode_i      (opcode),
        .funct_i       (funct),
        .alu_ctrl_o    (alu_ctrl),
        .funct_known_o (fn_known)
    );

    assign bus.ALU_Control = alu_ctrl;
    assign bus.CPU_MIO     = bus.MemRead | bus.MemWrite;
    assign bus.state_out   = reset ? 5'd0 : state_q;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Self-checking bench for mcpu_ctrl_fsm: directed vector table, reset corner cases, and
// randomized instruction streams against an instruction-path reference model.
module tb_mcpu_ctrl_fsm;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mcpu_ctrl_fsm_if bus();

    mcpu_ctrl_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // {MemRead, MemWrite, CPU_MIO, IorD, IRWrite, PCWrite, PCWriteCond, RegWrite, Branch,
    //  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALU_Control}
    logic [20:0] outs;
    assign outs = {bus.MemRead, bus.MemWrite, bus.CPU_MIO, bus.IorD, bus.IRWrite, bus.PCWrite,
                   bus.PCWriteCond, bus.RegWrite, bus.Branch, bus.RegDst, bus.MemtoReg,
                   bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALU_Control};

    localparam logic [20:0] RstOuts = 21'b0_0000_0000_0000_0000_0010;

    typedef int path_t[$];

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        int          len;
        logic [31:0] st;   // hex digit k from the left is the state in cycle k
        logic [7:0]  rdy;  // bit k from the left is MIO_ready in cycle k
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] fn_alu(input logic [5:0] fn);
        case (fn)
            6'h20: return 3'd2;
            6'h22: return 3'd6;
            6'h24: return 3'd0;
            6'h25: return 3'd1;
            6'h2A: return 3'd7;
            6'h27: return 3'd4;
            6'h02: return 3'd5;
            6'h26: return 3'd3;
            default: return 3'd2;
        endcase
    endfunction

    function automatic logic fn_ok(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h02, 6'h26};
    endfunction

    // Expected controls for a given state number, straight from the per-state output table.
    function automatic logic [20:0] exp_outs(input int st, input logic [5:0] op,
                                             input logic [5:0] fn, input logic rdy);
        logic mr = 0, mw = 0, iord = 0, irw = 0, pcw = 0, pcwc = 0, rw = 0, br = 0, sa = 0;
        logic [1:0] rd = 0, mtr = 0, sb = 0, ps = 0;
        logic [2:0] alu = 3'd2;
        case (st)
            0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; mtr = 2'b01; end
            5:  begin mw = 1; iord = 1; end
            6:  begin sa = 1; alu = fn_alu(fn); end
            7:  begin rw = fn_ok(fn); rd = 2'b01; end
            8:  begin sa = 1; alu = 3'd6; pcwc = 1; ps = 2'b01; br = (op == 6'h04); end
            9:  begin pcw = 1; ps = 2'b10; end
            10: begin
                sa = 1; sb = 2'b10;
                alu = (op == 6'h0A) ? 3'd7 : (op == 6'h0C) ? 3'd0 : (op == 6'h0D) ? 3'd1 : 3'd2;
            end
            11: rw = 1;
            12: begin rw = 1; rd = 2'b10; mtr = 2'b10; pcw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {mr, mw, mr | mw, iord, irw, pcw, pcwc, rw, br, rd, mtr, sa, sb, ps, alu};
    endfunction

    // Sequence of microsteps each instruction class walks through (excluding stalls).
    function automatic path_t get_path(input logic [5:0] op);
        case (op)
            6'h00:                      return '{0, 1, 6, 7};
            6'h23:                      return '{0, 1, 2, 3, 4};
            6'h2B:                      return '{0, 1, 2, 5};
            6'h04, 6'h05:               return '{0, 1, 8};
            6'h02:                      return '{0, 1, 9};
`ifdef MCPU_JAL_EN
            6'h03:                      return '{0, 1, 12};
`endif
            6'h08, 6'h0A, 6'h0C, 6'h0D: return '{0, 1, 10, 11};
            default:                    return '{0, 1};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_check(input string name, input int st, input logic [5:0] op,
                               input logic [5:0] fn, input logic rdy, input logic z);
        bus.Inst_in   = {op, 20'($urandom), fn};
        bus.MIO_ready = rdy;
        bus.zero      = z;
        #1;
        chk({name, ".state"}, 32'(bus.state_out), st);
        chk({name, ".outs"}, 32'(outs), 32'(exp_outs(st, op, fn, rdy)));
    endtask

    initial begin
        vecs[0]  = '{op: 6'h00, fn: 6'h20, zero: 0, len: 5, st: 32'h0167_0000, rdy: 8'hFF};
        vecs[1]  = '{op: 6'h23, fn: 6'h00, zero: 0, len: 8, st: 32'h0123_3340, rdy: 8'b1110_0111};
        vecs[2]  = '{op: 6'h04, fn: 6'h11, zero: 1, len: 4, st: 32'h0180_0000, rdy: 8'hFF};
        vecs[3]  = '{op: 6'h05, fn: 6'h11, zero: 1, len: 4, st: 32'h0180_0000, rdy: 8'hFF};
        vecs[4]  = '{op: 6'h3F, fn: 6'h20, zero: 0, len: 3, st: 32'h0100_0000, rdy: 8'hFF};
`ifdef MCPU_JAL_EN
        vecs[5]  = '{op: 6'h03, fn: 6'h00, zero: 0, len: 4, st: 32'h01C0_0000, rdy: 8'hFF};
`else
        vecs[5]  = '{op: 6'h03, fn: 6'h00, zero: 0, len: 3, st: 32'h0100_0000, rdy: 8'hFF};
`endif
        vecs[6]  = '{op: 6'h2B, fn: 6'h00, zero: 0, len: 6, st: 32'h0012_5000, rdy: 8'b0111_1111};
        vecs[7]  = '{op: 6'h00, fn: 6'h3F, zero: 0, len: 5, st: 32'h0167_0000, rdy: 8'hFF};
        vecs[8]  = '{op: 6'h02, fn: 6'h00, zero: 1, len: 4, st: 32'h0190_0000, rdy: 8'hFF};
        vecs[9]  = '{op: 6'h0A, fn: 6'h00, zero: 0, len: 5, st: 32'h01AB_0000, rdy: 8'hFF};
        vecs[10] = '{op: 6'h00, fn: 6'h02, zero: 0, len: 5, st: 32'h0167_0000, rdy: 8'hFF};
        vecs[11] = '{op: 6'h2B, fn: 6'h00, zero: 0, len: 6, st: 32'h0125_5000, rdy: 8'b1110_1111};

        // Reset state
        reset = 1'b1;
        bus.Inst_in = 32'h0;
        bus.MIO_ready = 1'b1;
        bus.zero = 1'b0;
        #1;
        chk("reset.state", 32'(bus.state_out), 0);
        chk("reset.outs", 32'(outs), 32'(RstOuts));
        step();
        step();
        chk("reset_held.outs", 32'(outs), 32'(RstOuts));
        reset = 1'b0;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < vecs[i].len; k++) begin
                drive_check($sformatf("vec%0d.c%0d", i, k), int'(vecs[i].st[31 - 4 * k -: 4]),
                            vecs[i].op, vecs[i].fn, vecs[i].rdy[7 - k], vecs[i].zero);
                if (k < vecs[i].len - 1) step();
            end
        end

        // Reset asserted while a store is waiting in MWR
        drive_check("mwr.if", 0, 6'h2B, 6'h00, 1'b1, 1'b0);
        step();
        drive_check("mwr.id", 1, 6'h2B, 6'h00, 1'b1, 1'b0);
        step();
        drive_check("mwr.ma", 2, 6'h2B, 6'h00, 1'b1, 1'b0);
        step();
        drive_check("mwr.mwr", 5, 6'h2B, 6'h00, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("mwr_rst.state", 32'(bus.state_out), 0);
        chk("mwr_rst.outs", 32'(outs), 32'(RstOuts));
        bus.MIO_ready = 1'b1;
        step();
        chk("mwr_rst_hold.state", 32'(bus.state_out), 0);
        chk("mwr_rst_hold.outs", 32'(outs), 32'(RstOuts));
        reset = 1'b0;
        drive_check("post_rst.wait", 0, 6'h2B, 6'h00, 1'b0, 1'b0);
        step();
        drive_check("post_rst.wait2", 0, 6'h2B, 6'h00, 1'b0, 1'b0);
        bus.MIO_ready = 1'b1;
        step();
        chk("post_rst.fetch", 32'(bus.state_out), 1);

        // Resynchronise to IF with an asynchronous pulse between edges
        reset = 1'b1;
        #1 reset = 1'b0;

        // Randomized instruction stream against the path model
        begin
            logic [5:0] ops[15];
            logic [5:0] fns[10];
            logic [5:0] op, fn;
            path_t      path;
            int         idx;
            logic       rdy;
            ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0A,
                    6'h0C, 6'h0D, 6'h3F, 6'h11, 6'h00};
            fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h02, 6'h26, 6'h3F, 6'h01};
            op = ops[$urandom_range(0, 14)];
            fn = fns[$urandom_range(0, 9)];
            path = get_path(op);
            idx = 0;
            for (int c = 0; c < 3000; c++) begin
                rdy = ($urandom_range(0, 3) != 0);
                drive_check("rand", path[idx], op, fn, rdy, 1'($urandom));
                if (!((path[idx] == 0 || path[idx] == 3 || path[idx] == 5) && !rdy)) idx++;
                if (idx == path.size()) begin
                    op = ops[$urandom_range(0, 14)];
                    fn = fns[$urandom_range(0, 9)];
                    path = get_path(op);
                    idx = 0;
                end
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mcpu_ctrl_fsm.md
# mcpu_ctrl_fsm

Multi-cycle MIPS-subset control unit: a Moore state machine that sequences the shared datapath (single memory port, one ALU, register file, PC, IR/MDR/A/B/ALUOut latches) one microstep per clock. It replaces the single-cycle decoder in the multi-cycle CPU core. It reads the latched instruction and ALU flags and drives every mux select, write enable and memory strobe. It stalls on memory handshake via `MIO_ready`.

## Interface
- `INIT_STATE`, default 5'd0 (IF): state entered on reset.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; forces state to IF.
- `Inst_in`  in  32  IR contents; only [31:26] and [5:0] are used.
- `zero`  in  1  ALU zero flag, valid in the branch-compare state.
- `MIO_ready`  in  1  memory/IO access completes this cycle.
- `MemRead`, `MemWrite`, `CPU_MIO`  out  1 each  memory strobes; `CPU_MIO` = `MemRead | MemWrite`.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `IRWrite`, `PCWrite`, `PCWriteCond`, `RegWrite`  out  1 each  write enables.
- `Branch`  out  1  conditional sense: 1 = beq (take if zero), 0 = bne.
- `RegDst`  out  2  00 rt, 01 rd, 10 $31.
- `MemtoReg`  out  2  00 ALUOut, 01 MDR, 10 PC.
- `ALUSrcA`  out  1  0 PC, 1 A.
- `ALUSrcB`  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `ALU_Control`  out  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt.
- `state_out`  out  5  current state encoding, for debug display.

## Operation
- States: IF(0), ID(1), MA(2, mem address), MRD(3), WBL(4), MWR(5), EXR(6), WBR(7), BR(8), JMP(9), EXI(10), WBI(11), JAL(12).
- IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSource=00; IRWrite = PCWrite = `MIO_ready`. Stay in IF until `MIO_ready`=1, then go to ID.
- ID: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Dispatch on opcode:
  - 0x00 → EXR; 0x23/0x2B → MA; 0x04/0x05 → BR; 0x02 → JMP; 0x03 → JAL; 0x08/0x0A/0x0C/0x0D → EXI.
  - Any other opcode → IF. This is a NOP: PC is already advanced and no write occurs.
- MA: ALUSrcA=1, ALUSrcB=10, add. Next state: lw → MRD, sw → MWR.
- MRD: MemRead=1, IorD=1. Hold until `MIO_ready`, then WBL. WBL: RegWrite=1, RegDst=00, MemtoReg=01 → IF.
- MWR: MemWrite=1, IorD=1. Hold until `MIO_ready`, then IF.
- EXR: ALUSrcA=1, ALUSrcB=00, ALU_Control from funct:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x27 nor, 0x02 srl, 0x26 xor.
  - Any other funct: add, and WBR suppresses RegWrite.
  - EXR → WBR. WBR: RegWrite=1, RegDst=01, MemtoReg=00 → IF.
- EXI: ALUSrcA=1, ALUSrcB=10; addi add, slti slt, andi and, ori or (immediate sign-extended). EXI → WBI. WBI: RegWrite=1, RegDst=00, MemtoReg=00 → IF.
- BR: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01, Branch = (opcode==0x04) → IF.
- JMP: PCWrite=1, PCSource=10 → IF.
- JAL: RegWrite=1, RegDst=10, MemtoReg=10, PCWrite=1, PCSource=10 → IF.
- Unlisted outputs are 0 in each state; ALU_Control defaults to add.

## Timing
- Outputs are a combinational function of registered state and `Inst_in`; there are no output registers.
- Cycle counts with zero wait:
  - 3 cycles: beq/bne, j, jal.
  - 4 cycles: R-type, I-ALU, sw.
  - 5 cycles: lw.
  - Each `MIO_ready`=0 cycle in IF/MRD/MWR adds one cycle. No enable fires in a stalled cycle.
- Reset asserted (async): state=IF immediately. While `reset`=1, all strobes and enables are 0, all selects are 0, `ALU_Control`=010, and `state_out`=0.
- Reset mid-instruction aborts without further writes. The first fetch happens on the first rising edge after deassertion where `MIO_ready`=1.
- The `zero` flag is sampled only in BR. It is ignored elsewhere.

## Configuration
- `MCPU_JAL_EN` defined: opcode 0x03 dispatches to JAL as above.
- Not defined: the JAL state is absent; opcode 0x03 is treated as illegal (ID → IF, no write); `state_out` never shows 12.

## Structure
- Package `mcpu_pkg` holds:
  - state encodings;
  - opcode and funct constants;
  - `ALU_Control` codes;
  - RegDst/MemtoReg/ALUSrcB/PCSource select codes.
- One sub-module, `mcpu_alu_dec`: maps funct/opcode to `ALU_Control` (combinational). It is instantiated once inside the FSM.

## Test plan
- Reset pulse, then `MIO_ready`=1 with `Inst_in`=add (op 0, funct 0x20) → `state_out` sequence 0,1,6,7,0; in WBR: RegWrite=1, RegDst=01; in EXR: `ALU_Control`=010.
- lw (op 0x23) with `MIO_ready` low for 2 cycles in MRD → sequence 0,1,2,3,3,3,4,0; in WBL: MemtoReg=01; in MRD: `CPU_MIO`=1.
- beq (op 0x04), `zero`=1 → in BR: PCWriteCond=1, Branch=1, PCSource=01, `ALU_Control`=110; bne (op 0x05) → Branch=0.
- `Inst_in` op 0x3F → 0,1,0 with no RegWrite/MemWrite/PCWriteCond asserted in ID.
- Assert `reset` while in MWR → state 0 asynchronously, MemWrite drops the same cycle, all enables 0 until deassert.
- jal (op 0x03) with `MCPU_JAL_EN` → 0,1,12,0 with RegDst=10, MemtoReg=10, PCSource=10; without macro → 0,1,0.
